rv_fetch_unit: RTL
==================

// Module: rv_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation RV32I core.
//  Owns the PC and issues word reads to the synchronous instruction memory, which
//  has 1-cycle read latency. Buffers returned instructions with their PCs in a
//  DEPTH-entry prefetch queue and hands them to decode over a valid/ready handshake.
//  A redirect from branch/jump resolution flushes the queue and in-flight fetch.
// PARAMETERS
//  XLEN          32   PC / address width
//  DEPTH         4    prefetch queue entries; power of 2, >=2 (>=3 for 1 inst/cycle)
//  RESET_VECTOR  0    PC value loaded on reset
//  IADDR_W       30   instruction-memory word-address width (<= XLEN-2)
// PORTS
//  i_Clk           in   1          clock, rising edge
//  i_Rst           in   1          asynchronous, active-low reset
//  i_Enb           in   1          fetch enable; low = issue no new requests
//  o_Imem_Req      out  1          read request this cycle
//  ov_Imem_Addr    out  IADDR_W    word address (fetch_pc[IADDR_W+1:2])
//  iv_Imem_Data    in   32         read data, valid the cycle after o_Imem_Req
//  i_Redirect      in   1          flush and restart at iv_Redirect_Pc
//  iv_Redirect_Pc  in   XLEN       target PC; bits [1:0] ignored (forced 0)
//  o_Inst_Valid    out  1          queue head valid
//  i_Inst_Ready    in   1          decode accepts head (pop when valid & ready)
//  ov_Inst         out  32         head instruction; 32'h00000013 (NOP) when !valid
//  ov_Inst_Pc      out  XLEN       head PC; 0 when !valid
//  ov_Inst_Pc4     out  XLEN       head PC + 4 (link value for JAL/JALR); 0 when !valid
//  ov_Count        out  clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset: fetch_pc=RESET_VECTOR, count=0, rd/wr ptr=0, inflight=0.
//   Outputs: o_Imem_Req=0, o_Inst_Valid=0, ov_Inst=NOP, ov_Inst_Pc/Pc4=0, ov_Count=0.
//   Queue storage is not reset; masking of the head outputs covers it.
//  Issue: o_Imem_Req = i_Enb & !i_Redirect & (count + inflight < DEPTH).
//   - Combinational, with no path from i_Inst_Ready.
//   - On issue: req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4 (wraps mod 2^XLEN);
//     inflight <= 1. Otherwise inflight <= 0.
//  Response: when inflight=1, {iv_Imem_Data, req_pc} is written at wr_ptr.
//   - Credit check guarantees the queue is never full at push.
//   - The response is captured even if i_Enb has since dropped.
//  Pop: valid & ready advances rd_ptr.
//   - Simultaneous push and pop: count unchanged.
//   - Pointers wrap mod DEPTH.
//  Latency: request at N, data at N+1, head visible at N+2. No bypass path.
//  Redirect (priority over all else), at the edge:
//   - count=0, wr_ptr=rd_ptr=0, inflight=0; the response arriving next cycle is
//     dropped.
//   - fetch_pc <= {iv_Redirect_Pc[XLEN-1:2],2'b00}.
//   - Any pop in the same cycle is discarded.
//   - First request for the target in N+1; target head valid at N+3.
//  Reset asserted mid-operation: all state returns to reset values immediately;
//   no partial response is retained.
//  Steady state with DEPTH>=3, ready=1: one instruction per cycle.
//   DEPTH=2 gives one instruction per two cycles.
// STRUCTURE
//  rv_defs.vh (shared): NOP_INST=32'h00000013, XLEN default, IADDR_W default.
//  Sub-module fetch_queue: sync FIFO parametrised on WIDTH/DEPTH with push/pop/
//   flush/count. Stores {pc, inst}; head output is unregistered from storage.
//  Top level holds fetch_pc, req_pc, inflight, credit/issue logic and output masking.
// TESTING
//  1 Reset, RESET_VECTOR=0, i_Enb=1, ready=1: addresses 0,1,2,..., one per cycle
//    from cycle 0. Heads carry PC 0x0,0x4,0x8; first valid at cycle 2.
//  2 ready=0, DEPTH=4: exactly 4 requests, then o_Imem_Req=0 and ov_Count=4.
//    ready=1 for 1 cycle: head PC 0x0 pops; a new request issues the next cycle.
//  3 Redirect to 0x104 while count=3 and inflight=1:
//    - next cycle: count=0, valid=0, ov_Imem_Addr=0x41, stale data dropped;
//    - head PC 0x104 valid 3 cycles after redirect.
//  4 Redirect with iv_Redirect_Pc=0x1FF: fetch restarts at 0x1FC.
//    Redirect plus pop in the same cycle: no double pop, count=0.
//  5 PC wrap: RESET_VECTOR=32'hFFFFFFF8 gives heads FFFFFFF8, FFFFFFFC, 00000000;
//    ov_Inst_Pc4 of the last head is 0x4.
//  6 Drop i_Enb while inflight: the response is still enqueued and no further
//    requests issue. Assert i_Rst low mid-stream: all outputs at reset values
//    asynchronously.

Source files
------------

// File: rtl/rv_fetch_unit_pkg.sv
// Shared definitions for the RV32I instruction-fetch front end.
//   NopInst        : canonical NOP (addi x0, x0, 0) shown on an empty queue head
//   XlenDefault    : default PC / address width
//   IaddrWDefault  : default instruction-memory word-address width
//   DepthDefault   : default prefetch queue depth
package rv_fetch_unit_pkg;

  localparam logic [31:0] NopInst       = 32'h0000_0013;
  localparam int unsigned XlenDefault   = 32;
  localparam int unsigned IaddrWDefault = 30;
  localparam int unsigned DepthDefault  = 4;

endpackage

// File: rtl/rv_fetch_unit_fetch_queue.sv
// Synchronous FIFO holding {pc, inst} pairs for the fetch unit.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write wdata_i at the tail
//   pop_i         : advance the head (caller guarantees non-empty)
//   flush_i       : empty the queue; overrides push and pop
//   wdata_i       : entry to write
//   rdata_o       : head entry, read combinationally from storage
//   count_o       : occupied entries
module rv_fetch_unit_fetch_queue #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Depth is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i) begin
        count_d = count_q + CntW'(1);
      end else if (!push_i && pop_i) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; the consumer masks the head when empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word reads to a 1-cycle
// synchronous instruction memory, buffers {pc, inst} in a prefetch queue and
// presents the head to decode over valid/ready. A redirect flushes everything.
// Ports:
//   i_Clk, i_Rst          : clock, asynchronous active-low reset
//   i_Enb                 : fetch enable (low = no new requests)
//   o_Imem_Req            : read request this cycle
//   ov_Imem_Addr          : word address of the request
//   iv_Imem_Data          : read data, valid the cycle after a request
//   i_Redirect            : flush and restart at iv_Redirect_Pc
//   iv_Redirect_Pc        : redirect target (low two bits ignored)
//   o_Inst_Valid          : queue head valid
//   i_Inst_Ready          : decode accepts head
//   ov_Inst               : head instruction, NOP when not valid
//   ov_Inst_Pc            : head PC, 0 when not valid
//   ov_Inst_Pc4           : head PC + 4, 0 when not valid
//   ov_Count              : occupied queue entries
module rv_fetch_unit
  import rv_fetch_unit_pkg::*;
#(
  parameter int unsigned      XLEN         = XlenDefault,
  parameter int unsigned      DEPTH        = DepthDefault,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      IADDR_W      = IaddrWDefault,
  localparam int unsigned     CntW         = $clog2(DEPTH + 1)
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Enb,
  output logic               o_Imem_Req,
  output logic [IADDR_W-1:0] ov_Imem_Addr,
  input  logic [31:0]        iv_Imem_Data,
  input  logic               i_Redirect,
  input  logic [XLEN-1:0]    iv_Redirect_Pc,
  output logic               o_Inst_Valid,
  input  logic               i_Inst_Ready,
  output logic [31:0]        ov_Inst,
  output logic [XLEN-1:0]    ov_Inst_Pc,
  output logic [XLEN-1:0]    ov_Inst_Pc4,
  output logic [CntW-1:0]    ov_Count
);

  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic [CntW-1:0]    count;
  logic [CntW:0]      occupancy;
  logic               issue, push, pop, valid;
  logic [XLEN+31:0]   head;
  logic [XLEN-1:0]    head_pc;
  logic               unused_redirect_lsb;

  assign unused_redirect_lsb = ^iv_Redirect_Pc[1:0];

  // Credit: entries held plus the one possibly in flight must leave room for the
  // response, so the queue can never be full when data returns.
  assign occupancy = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
  assign issue     = i_Enb & ~i_Redirect & (occupancy < DepthLim);
  assign push      = inflight_q & ~i_Redirect;
  assign valid     = (count != '0);
  assign pop       = valid & i_Inst_Ready & ~i_Redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (i_Redirect) begin
      fetch_pc_d = {iv_Redirect_Pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      fetch_pc_q <= RESET_VECTOR;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  rv_fetch_unit_fetch_queue #(
    .Width (XLEN + 32),
    .Depth (DEPTH)
  ) u_queue (
    .clk_i   (i_Clk),
    .rst_ni  (i_Rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_Redirect),
    .wdata_i ({req_pc_q, iv_Imem_Data}),
    .rdata_o (head),
    .count_o (count)
  );

  assign head_pc = head[XLEN+31:32];

  // Request is gated by reset directly so it drops the instant reset asserts,
  // not only after the credit state has cleared.
  assign o_Imem_Req   = i_Rst & issue;
  assign ov_Imem_Addr = fetch_pc_q[IADDR_W+1:2];
  assign o_Inst_Valid = valid;
  assign ov_Inst      = valid ? head[31:0] : NopInst;
  assign ov_Inst_Pc   = valid ? head_pc : '0;
  assign ov_Inst_Pc4  = valid ? head_pc + XLEN'(4) : '0;
  assign ov_Count     = count;

endmodule
